ps2_transmitter: RTL and testbench
==================================

PS2_TRANSMITTER -- requirements
Module: ps2_transmitter

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 12000, is the clock-low request hold time in clk cycles (120 us at 100 MHz).
REQ-002 Parameter START_TIMEOUT, default 1500000, is the maximum wait in clk cycles for the device's first clock falling edge (15 ms).
REQ-003 Parameter XFER_TIMEOUT, default 200000, is the maximum time in clk cycles from the first falling edge to line idle (2 ms).
REQ-004 clk  in  1  system clock (100 MHz board clock, same domain as the keyboard receiver).
REQ-005 rst  in  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
REQ-006 kclk_in  in  1  raw PS/2 clock line level, asynchronous.
REQ-007 kdata_in  in  1  raw PS/2 data line level, asynchronous.
REQ-008 kclk_oe  out  1  1 = pull PS/2 clock low (open-drain); 0 = release.
REQ-009 kdata_oe  out  1  1 = pull PS/2 data low (open-drain); 0 = release.
REQ-010 tx_valid  in  1  command byte offered.
REQ-011 tx_data  in  8  command byte (e.g. 0xED set-LEDs, 0xFF reset).
REQ-012 tx_ready  out  1  high only in IDLE; transfer accepted on the cycle tx_valid && tx_ready.
REQ-013 done  out  1  one-cycle pulse when a transfer ends, successfully or not.
REQ-014 err  out  2  result, valid with done: 00 ok, 01 start timeout, 10 transfer timeout, 11 device NACK.
REQ-015 busy  out  1  high in every state except IDLE; the receiver uses it to ignore line activity.

Function
REQ-016 kclk_in and kdata_in each pass through a 2-FF synchronizer; a falling edge is synced-high-then-synced-low on consecutive cycles.
REQ-017 States: IDLE, INHIBIT, REQ, SEND, WAIT_IDLE; all outputs are registered.
REQ-018 IDLE: both lines released; on acceptance, latch tx_data, compute parity = ~^tx_data (odd), clear edge count, go to INHIBIT.
REQ-019 INHIBIT: kclk_oe=1, kdata_oe=0 for exactly INHIBIT_CYCLES cycles, then REQ.
REQ-020 REQ: kclk_oe=1, kdata_oe=1 for exactly 1 cycle, then SEND with kclk_oe=0 and kdata_oe=1 (start bit).
REQ-021 SEND: falling edges counted 1..11; after edge k (1..8), kdata_oe = ~data[k-1] on the next cycle; after edge 9, kdata_oe = ~parity; after edge 10, kdata_oe=0 (stop bit).
REQ-022 At edge 11, sample synced kdata: 0 = ACK and go to WAIT_IDLE; 1 = NACK, err=11.
REQ-023 If SEND sees no falling edge within START_TIMEOUT cycles of entry: err=01.
REQ-024 If edge 11 plus both synced lines high is not reached within XFER_TIMEOUT cycles of edge 1: err=10; this timer also bounds WAIT_IDLE.
REQ-025 WAIT_IDLE: lines released; when synced kclk and kdata are both high, pulse done with err=00 and return to IDLE.
REQ-026 Every error path releases both lines, pulses done with its code for one cycle, and returns to IDLE the same cycle.
REQ-027 tx_valid while busy is ignored and not queued; a new byte is accepted on the first IDLE cycle after done.
REQ-028 Counters are sized $clog2(param+1) and saturate; no wrap-around can produce a false timeout release.

Reset
REQ-029 While rst=0: state=IDLE; kclk_oe=kdata_oe=0; done=0; err=00; busy=0; tx_ready=1 from the first cycle after rst returns high.
REQ-030 Reset mid-transfer aborts silently: lines are released on the next clk edge and done is not pulsed.

Structure
REQ-031 Package ps2_pkg holds the state encoding, the err code constants, and the default timing constants; the receiver shares it.
REQ-032 One sub-module, ps2_line_sync (2-FF sync plus falling-edge pulse), is instantiated once per line.

Verification (bench models an open-drain device; INHIBIT_CYCLES=100, START_TIMEOUT=5000, XFER_TIMEOUT=20000)
REQ-033 Send 0xED, device ACKs -> kclk_oe high 100 cycles, bits 1,0,1,1,0,1,1,1, parity 1, stop released; done with err=00.
REQ-034 Send 0x00, 0x01, 0xFF -> parity bits 1, 0, 1 respectively; err=00.
REQ-035 Device never clocks -> done exactly 5000 cycles after SEND entry with err=01; kclk_oe=kdata_oe=0.
REQ-036 Device holds kdata high at edge 11 -> err=11; device stops clocking after edge 6 -> err=10.
REQ-037 rst=0 right after edge 5 -> next cycle kclk_oe=kdata_oe=0, no done; a following send of 0xFF completes with err=00.
REQ-038 tx_valid pulsed with 0x55 during SEND -> ignored; the in-flight byte is sent unchanged and only one done occurs.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, result codes and default timing.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_SEND,
        ST_WAIT_IDLE
    } ps2_state_t;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_START = 2'b01;
    localparam logic [1:0] ERR_XFER  = 2'b10;
    localparam logic [1:0] ERR_NACK  = 2'b11;

    // 100 MHz clock: 120 us inhibit, 15 ms start window, 2 ms transfer window
    localparam int INHIBIT_CYCLES_DEF = 12000;
    localparam int START_TIMEOUT_DEF  = 1500000;
    localparam int XFER_TIMEOUT_DEF   = 200000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one raw PS/2 line plus a falling-edge strobe.
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_line,
    output logic o_sync,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Idle bus level is high, so reset to 1 to avoid a phantom edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_line;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/ps2_transmitter.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, clocked-out
// frame under device clock, ACK check and timeouts on open-drain line enables.
module ps2_transmitter
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
    parameter int START_TIMEOUT  = START_TIMEOUT_DEF,
    parameter int XFER_TIMEOUT   = XFER_TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kclk_in,
    input  logic       kdata_in,
    output logic       kclk_oe,
    output logic       kdata_oe,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       done,
    output logic [1:0] err,
    output logic       busy
);

    localparam int TMAX = max3(INHIBIT_CYCLES, START_TIMEOUT, XFER_TIMEOUT);
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] TMAX_V    = TW'(TMAX);
    localparam logic [TW-1:0] INH_LIM   = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] START_LIM = TW'(START_TIMEOUT - 1);
    localparam logic [TW-1:0] XFER_LIM  = TW'(XFER_TIMEOUT - 1);

    ps2_state_t    r_state;
    logic [TW-1:0] r_timer;
    logic [3:0]    r_edges;
    logic [7:0]    r_data;
    logic          r_parity;

    logic          w_kclk_sync;
    logic          w_kclk_fall;
    logic          w_kdata_sync;
    logic          w_kdata_fall;
    logic [TW-1:0] w_timer_inc;
    logic          w_lines_idle;

    ps2_line_sync u_kclk_sync (
        .clk    (clk),
        .rst    (rst),
        .i_line (kclk_in),
        .o_sync (w_kclk_sync),
        .o_fall (w_kclk_fall)
    );

    ps2_line_sync u_kdata_sync (
        .clk    (clk),
        .rst    (rst),
        .i_line (kdata_in),
        .o_sync (w_kdata_sync),
        .o_fall (w_kdata_fall)
    );

    // One shared saturating timer; sized for the longest window so it never wraps.
    assign w_timer_inc  = (r_timer == TMAX_V) ? r_timer : r_timer + TW'(1);
    assign w_lines_idle = w_kclk_sync & w_kdata_sync & ~w_kclk_fall & ~w_kdata_fall;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_timer  <= '0;
            r_edges  <= '0;
            r_data   <= '0;
            r_parity <= 1'b0;
            kclk_oe  <= 1'b0;
            kdata_oe <= 1'b0;
            done     <= 1'b0;
            err      <= ERR_OK;
            busy     <= 1'b0;
            tx_ready <= 1'b1;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (tx_valid && tx_ready) begin
                        r_data   <= tx_data;
                        r_parity <= ~^tx_data;
                        r_edges  <= '0;
                        r_timer  <= '0;
                        r_state  <= ST_INHIBIT;
                        kclk_oe  <= 1'b1;
                        kdata_oe <= 1'b0;
                        busy     <= 1'b1;
                        tx_ready <= 1'b0;
                    end
                end
                ST_INHIBIT: begin
                    if (r_timer >= INH_LIM) begin
                        r_state  <= ST_REQ;
                        kdata_oe <= 1'b1;
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end
                ST_REQ: begin
                    r_state <= ST_SEND;
                    kclk_oe <= 1'b0;
                    r_timer <= '0;
                end
                ST_SEND: begin
                    if (w_kclk_fall) begin
                        r_edges <= r_edges + 4'd1;
                        r_timer <= (r_edges == 4'd0) ? '0 : w_timer_inc;
                        if (r_edges <= 4'd7) begin
                            kdata_oe <= ~r_data[r_edges[2:0]];
                        end else if (r_edges == 4'd8) begin
                            kdata_oe <= ~r_parity;
                        end else if (r_edges == 4'd9) begin
                            kdata_oe <= 1'b0;
                        end else if (!w_kdata_sync) begin
                            r_state  <= ST_WAIT_IDLE;
                            kdata_oe <= 1'b0;
                        end else begin
                            r_state  <= ST_IDLE;
                            kdata_oe <= 1'b0;
                            done     <= 1'b1;
                            err      <= ERR_NACK;
                            busy     <= 1'b0;
                            tx_ready <= 1'b1;
                        end
                    end else if (r_edges == 4'd0 && r_timer >= START_LIM) begin
                        r_state  <= ST_IDLE;
                        kclk_oe  <= 1'b0;
                        kdata_oe <= 1'b0;
                        done     <= 1'b1;
                        err      <= ERR_START;
                        busy     <= 1'b0;
                        tx_ready <= 1'b1;
                    end else if (r_edges != 4'd0 && r_timer >= XFER_LIM) begin
                        r_state  <= ST_IDLE;
                        kclk_oe  <= 1'b0;
                        kdata_oe <= 1'b0;
                        done     <= 1'b1;
                        err      <= ERR_XFER;
                        busy     <= 1'b0;
                        tx_ready <= 1'b1;
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (w_lines_idle) begin
                        r_state  <= ST_IDLE;
                        done     <= 1'b1;
                        err      <= ERR_OK;
                        busy     <= 1'b0;
                        tx_ready <= 1'b1;
                    end else if (r_timer >= XFER_LIM) begin
                        r_state  <= ST_IDLE;
                        kclk_oe  <= 1'b0;
                        kdata_oe <= 1'b0;
                        done     <= 1'b1;
                        err      <= ERR_XFER;
                        busy     <= 1'b0;
                        tx_ready <= 1'b1;
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_transmitter.sv
// Directed bench for ps2_transmitter with an open-drain device model and a result scoreboard.
module tb_ps2_transmitter;
    import ps2_pkg::*;

    localparam int INH = 100;
    localparam int STO = 5000;
    localparam int XTO = 20000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       kclk_line;
    logic       kdata_line;
    logic       kclk_oe, kdata_oe;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, done, busy;
    logic [1:0] err;

    assign kclk_line  = dev_clk & ~kclk_oe;
    assign kdata_line = dev_data & ~kdata_oe;

    always #5 clk = ~clk;

    ps2_transmitter #(
        .INHIBIT_CYCLES (INH),
        .START_TIMEOUT  (STO),
        .XFER_TIMEOUT   (XTO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .kclk_in  (kclk_line),
        .kdata_in (kdata_line),
        .kclk_oe  (kclk_oe),
        .kdata_oe (kdata_oe),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .done     (done),
        .err      (err),
        .busy     (busy)
    );

    typedef struct packed {
        logic [1:0]  err;
        logic [10:0] frame;
        logic        full;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_assert = 0;
    int          n_fail = 0;
    int          n_done = 0;
    int          cyc_cnt = 0;
    int          t_done = 0;
    logic        prev_done = 1'b0;
    logic [10:0] cap = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d);
        logic par;
        par = (($countones(d) % 2) == 0);
        return {1'b1, par, d, 1'b0};
    endfunction

    task automatic wait_dones(input int target, input int lim);
        int t;
        t = 0;
        while (n_done < target && t < lim) begin
            cyc(1);
            t++;
        end
        chk("done_seen", 32'(n_done >= target), 1);
    endtask

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Scoreboard side: every done pops one expectation.
    always @(negedge clk) begin
        if (rst && done) begin
            n_done++;
            t_done = cyc_cnt;
            chk("done_one_cycle", prev_done, 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 0, 1);
            end else begin
                mon_e = exp_q.pop_front();
                chk("err_code", err, mon_e.err);
                chk("lines_released", {kclk_oe, kdata_oe}, 0);
                if (mon_e.full) chk("frame_bits", cap, mon_e.frame);
            end
        end
        prev_done <= done;
    end

    // nedges: device falling edges produced; abort5: reset right after edge 5
    task automatic send(input logic [7:0] d, input int nedges, input bit ack,
                        input bit inject, input bit abort5, input logic [1:0] exp_err);
        int   n;
        int   t0;
        int   base;
        exp_t e;
        base = n_done;
        if (!abort5) begin
            e.err   = exp_err;
            e.frame = mk_frame(d);
            e.full  = (nedges == 11);
            exp_q.push_back(e);
        end
        n = 0;
        while (!tx_ready && n < 100) begin
            cyc(1);
            n++;
        end
        tx_data  = d;
        tx_valid = 1'b1;
        cyc(1);
        tx_valid = 1'b0;
        chk("busy_on", busy, 1);
        chk("ready_off", tx_ready, 0);
        n = 0;
        while (kclk_oe && !kdata_oe && n < 1000) begin
            n++;
            cyc(1);
        end
        chk("inhibit_len", n, INH);
        chk("req_both", {kclk_oe, kdata_oe}, 2'b11);
        cyc(1);
        chk("send_start", {kclk_oe, kdata_oe}, 2'b01);
        t0  = cyc_cnt;
        cap = '0;
        if (nedges == 0) begin
            wait_dones(base + 1, STO + 100);
            chk("start_timeout_cycles", t_done - t0, STO);
            return;
        end
        for (int k = 1; k <= nedges; k++) begin
            cyc(15);
            cap[k-1] = kdata_line;
            if (k == 11 && ack) dev_data = 1'b0;
            if (inject && k == 3) begin
                tx_data  = 8'h55;
                tx_valid = 1'b1;
                cyc(1);
                tx_valid = 1'b0;
                chk("ready_low_in_send", tx_ready, 0);
            end
            cyc(5);
            dev_clk = 1'b0;
            if (abort5 && k == 5) begin
                cyc(4);
                rst = 1'b0;
                cyc(1);
                chk("abort_released", {kclk_oe, kdata_oe}, 0);
                chk("abort_no_done", done, 0);
                cyc(2);
                rst = 1'b1;
                dev_clk = 1'b1;
                cyc(1);
                chk("abort_ready", tx_ready, 1);
                break;
            end
            cyc(20);
            dev_clk = 1'b1;
        end
        cyc(3);
        dev_data = 1'b1;
        if (abort5) begin
            cyc(200);
            chk("abort_done_count", n_done, base);
        end else begin
            wait_dones(base + 1, (nedges == 11) ? 2000 : XTO + 1000);
        end
    endtask

    initial begin
        rst = 1'b0;
        cyc(3);
        chk("rst_oe", {kclk_oe, kdata_oe}, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, ERR_OK);
        chk("rst_busy", busy, 0);
        rst = 1'b1;
        cyc(1);
        chk("rst_ready", tx_ready, 1);
        chk("rst_busy_after", busy, 0);

        send(8'hED, 11, 1'b1, 1'b0, 1'b0, ERR_OK);
        send(8'h00, 11, 1'b1, 1'b0, 1'b0, ERR_OK);
        send(8'h01, 11, 1'b1, 1'b0, 1'b0, ERR_OK);
        send(8'hFF, 11, 1'b1, 1'b0, 1'b0, ERR_OK);
        send(8'hA5, 0,  1'b0, 1'b0, 1'b0, ERR_START);
        chk("idle_after_start_to", busy, 0);
        send(8'h3C, 11, 1'b0, 1'b0, 1'b0, ERR_NACK);
        send(8'hC3, 6,  1'b1, 1'b0, 1'b0, ERR_XFER);
        send(8'h5A, 5,  1'b1, 1'b0, 1'b1, ERR_OK);
        send(8'hFF, 11, 1'b1, 1'b0, 1'b0, ERR_OK);
        begin
            int base;
            base = n_done;
            send(8'hED, 11, 1'b1, 1'b1, 1'b0, ERR_OK);
            cyc(300);
            chk("single_done_inject", n_done, base + 1);
            chk("idle_after_inject", busy, 0);
        end
        chk("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
